// File: rtl/bcd_pkg.sv
// BCD digit type, digit limits and per-digit step helpers shared by the
// decimal counter and its digit cells.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic logic is_valid_bcd(input bcd_t d);
    return (d <= BCD_MAX);
  endfunction

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == BCD_MAX) ? BCD_MIN : bcd_t'(d + 4'd1);
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t d);
    return (d == BCD_MIN) ? BCD_MAX : bcd_t'(d - 4'd1);
  endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// Key, control and display bundle between the game logic (master) and the
// decimal counter (slave).
interface bcd_counter_if #(
  parameter int NUM_DIGITS = 2
);

  logic                    up_key;
  logic                    down_key;
  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    overflow;
  logic                    underflow;
  logic                    load_err;
  logic                    at_zero;

  modport master (
    output up_key, down_key, clear, load, load_value,
    input  digits, overflow, underflow, load_err, at_zero
  );

  modport slave (
    input  up_key, down_key, clear, load, load_value,
    output digits, overflow, underflow, load_err, at_zero
  );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit: parallel set, increment with carry out, decrement with
// borrow out. Set wins over stepping; inc and dec together hold the digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic set_en,
  input  bcd_t set_val,
  output bcd_t value,
  output logic carry_out,
  output logic borrow_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= BCD_MIN;
    end else if (set_en) begin
      value <= set_val;
    end else if (inc && !dec) begin
      value <= bcd_inc(value);
    end else if (dec && !inc) begin
      value <= bcd_dec(value);
    end
  end

  assign carry_out  = inc && (value == BCD_MAX);
  assign borrow_out = dec && (value == BCD_MIN);

endmodule

// File: rtl/key_edge.sv
// Two-flop synchroniser for a raw key plus a third flop that turns the
// first synchronised high sample into a single-cycle pulse.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit decimal up/down counter driven by raw keys, with clear, checked
// parallel load and registered wrap/saturation/load-error strobes.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int SATURATE   = 0
) (
  input logic          clk,
  input logic          reset,
  bcd_counter_if.slave bus
);

  logic                    up_pulse;
  logic                    down_pulse;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    all_nine;
  logic                    all_zero;
  logic                    load_ok;
  logic                    idle;
  logic                    up_only;
  logic                    down_only;
  logic                    up_step;
  logic                    down_step;
  logic                    set_en;
  logic                    top_carry;
  logic                    top_borrow;
  logic                    overflow_next;
  logic                    underflow_next;
  logic                    load_rej;
  logic                    overflow_q;
  logic                    underflow_q;
  logic                    load_err_q;

  key_edge u_up_key (
    .clk   (clk),
    .reset (reset),
    .key   (bus.up_key),
    .pulse (up_pulse)
  );

  key_edge u_down_key (
    .clk   (clk),
    .reset (reset),
    .key   (bus.down_key),
    .pulse (down_pulse)
  );

  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    load_ok  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits[4*i +: 4] != BCD_MAX) all_nine = 1'b0;
      if (digits[4*i +: 4] != BCD_MIN) all_zero = 1'b0;
      if (!is_valid_bcd(bus.load_value[4*i +: 4])) load_ok = 1'b0;
    end
  end

  // clear beats load beats counting; coincident up/down presses cancel
  assign idle      = !bus.clear && !bus.load;
  assign up_only   = idle && up_pulse && !down_pulse;
  assign down_only = idle && down_pulse && !up_pulse;
  assign up_step   = up_only && !((SATURATE != 0) && all_nine);
  assign down_step = down_only && !((SATURATE != 0) && all_zero);
  assign set_en    = bus.clear || (bus.load && load_ok);
  assign load_rej  = !bus.clear && bus.load && !load_ok;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic inc;
    logic dec;
    logic carry;
    logic borrow;
    bcd_t set_val;

    if (i == 0) begin : g_lsd
      assign inc = up_step;
      assign dec = down_step;
    end else begin : g_chain
      assign inc = g_digit[i-1].carry;
      assign dec = g_digit[i-1].borrow;
    end

    assign set_val = bus.clear ? BCD_MIN : bus.load_value[4*i +: 4];

    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .inc        (inc),
      .dec        (dec),
      .set_en     (set_en),
      .set_val    (set_val),
      .value      (digits[4*i +: 4]),
      .carry_out  (carry),
      .borrow_out (borrow)
    );
  end

  assign top_carry  = g_digit[NUM_DIGITS-1].carry;
  assign top_borrow = g_digit[NUM_DIGITS-1].borrow;

  // When wrapping, the event is exactly the ripple leaving the top digit;
  // when saturating that ripple is suppressed, so the boundary is tested directly.
  assign overflow_next  = (SATURATE != 0) ? (up_only && all_nine)   : top_carry;
  assign underflow_next = (SATURATE != 0) ? (down_only && all_zero) : top_borrow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      overflow_q  <= overflow_next;
      underflow_q <= underflow_next;
      load_err_q  <= load_rej;
    end
  end

  assign bus.digits    = digits;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.load_err  = load_err_q;
  assign bus.at_zero   = all_zero;

endmodule

// File: tb/tb_bcd_counter.sv
// Drives a wrapping and a saturating two-digit counter with identical stimulus
// and compares both against an integer model of the count.
module tb_bcd_counter;

  localparam int NUM_DIGITS = 2;
  localparam int MAXV       = 99;

  logic       clk;
  logic       rst_n;
  logic       up_key;
  logic       down_key;
  logic       clear;
  logic       load;
  logic [7:0] load_value;

  bcd_counter_if #(.NUM_DIGITS(NUM_DIGITS)) bus_wrap ();
  bcd_counter_if #(.NUM_DIGITS(NUM_DIGITS)) bus_sat ();

  assign bus_wrap.up_key     = up_key;
  assign bus_wrap.down_key   = down_key;
  assign bus_wrap.clear      = clear;
  assign bus_wrap.load       = load;
  assign bus_wrap.load_value = load_value;
  assign bus_sat.up_key      = up_key;
  assign bus_sat.down_key    = down_key;
  assign bus_sat.clear       = clear;
  assign bus_sat.load        = load;
  assign bus_sat.load_value  = load_value;

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS), .SATURATE(0)) dut_wrap (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_wrap)
  );

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS), .SATURATE(1)) dut_sat (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_compared;
  int   n_mismatched;
  // index 0 models the wrapping counter, index 1 the saturating one
  int   model_cnt [2];
  logic model_ovf  [2];
  logic model_unf  [2];
  logic model_lerr [2];
  int   up_due [$];
  int   down_due [$];
  logic up_last;
  logic down_last;
  int   edge_n;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  function automatic int bcd_to_int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int_to_bcd(input int n);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(n / 10);
    ones = 4'(n % 10);
    return {tens, ones};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      model_cnt[s]  = 0;
      model_ovf[s]  = 1'b0;
      model_unf[s]  = 1'b0;
      model_lerr[s] = 1'b0;
    end
    up_due.delete();
    down_due.delete();
    up_last   = 1'b0;
    down_last = 1'b0;
  endtask

  // A press is a low-to-high change between consecutive samples; it takes
  // effect on the second edge after the first high sample.
  task automatic model_edge();
    bit up_p;
    bit down_p;
    edge_n++;
    up_p   = 1'b0;
    down_p = 1'b0;
    if (up_due.size() > 0 && up_due[0] == edge_n) begin
      up_p = 1'b1;
      void'(up_due.pop_front());
    end
    if (down_due.size() > 0 && down_due[0] == edge_n) begin
      down_p = 1'b1;
      void'(down_due.pop_front());
    end
    if (up_key && !up_last) up_due.push_back(edge_n + 2);
    if (down_key && !down_last) down_due.push_back(edge_n + 2);
    up_last   = up_key;
    down_last = down_key;

    for (int s = 0; s < 2; s++) begin
      model_ovf[s]  = 1'b0;
      model_unf[s]  = 1'b0;
      model_lerr[s] = 1'b0;
      if (clear) begin
        model_cnt[s] = 0;
      end else if (load) begin
        if (bcd_ok(load_value)) model_cnt[s] = bcd_to_int(load_value);
        else model_lerr[s] = 1'b1;
      end else if (up_p && !down_p) begin
        if (model_cnt[s] == MAXV) begin
          model_ovf[s] = 1'b1;
          model_cnt[s] = (s == 1) ? MAXV : 0;
        end else begin
          model_cnt[s] = model_cnt[s] + 1;
        end
      end else if (down_p && !up_p) begin
        if (model_cnt[s] == 0) begin
          model_unf[s] = 1'b1;
          model_cnt[s] = (s == 1) ? 0 : MAXV;
        end else begin
          model_cnt[s] = model_cnt[s] - 1;
        end
      end
    end
  endtask

  task automatic check_dut(input int s, input logic [7:0] dg, input logic ovf,
                           input logic unf, input logic lerr, input logic zero);
    string p;
    p = (s == 0) ? "wrap" : "sat";
    checkOutput({p, "_digits"}, dg, int_to_bcd(model_cnt[s]));
    checkOutput({p, "_overflow"}, ovf, model_ovf[s]);
    checkOutput({p, "_underflow"}, unf, model_unf[s]);
    checkOutput({p, "_load_err"}, lerr, model_lerr[s]);
    checkOutput({p, "_at_zero"}, zero, (model_cnt[s] == 0));
    checkOutput({p, "_digit_range"}, (dg[3:0] <= 4'd9) && (dg[7:4] <= 4'd9), 1'b1);
  endtask

  task automatic applyStimulus(input logic u, input logic d, input logic c,
                               input logic l, input logic [7:0] v);
    up_key     = u;
    down_key   = d;
    clear      = c;
    load       = l;
    load_value = v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_dut(0, bus_wrap.digits, bus_wrap.overflow, bus_wrap.underflow,
              bus_wrap.load_err, bus_wrap.at_zero);
    check_dut(1, bus_sat.digits, bus_sat.overflow, bus_sat.underflow,
              bus_sat.load_err, bus_sat.at_zero);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic expect_both(input string tag, input logic [7:0] d_wrap,
                             input logic [7:0] d_sat);
    checkOutput({tag, "_wrap"}, bus_wrap.digits, d_wrap);
    checkOutput({tag, "_sat"}, bus_sat.digits, d_sat);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       u_s;
    logic       d_s;
    logic       c_r;
    logic       l_r;
    logic [7:0] v_r;

    n_compared   = 0;
    n_mismatched = 0;
    edge_n       = 0;
    rst_n        = 1'b0;
    up_key       = 1'b0;
    down_key     = 1'b0;
    clear        = 1'b0;
    load         = 1'b0;
    load_value   = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    expect_both("reset_digits", 8'h00, 8'h00);
    checkOutput("reset_overflow", bus_wrap.overflow, 1'b0);
    checkOutput("reset_load_err", bus_sat.load_err, 1'b0);
    checkOutput("reset_at_zero", bus_wrap.at_zero, 1'b1);

    // held key: one step on the third edge counting the first sample
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_both("hold_edge1", 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_both("hold_edge2", 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_both("hold_edge3", 8'h01, 8'h01);
    repeat (17) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_both("hold_end", 8'h01, 8'h01);
    idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle();
    idle();
    expect_both("repress", 8'h02, 8'h02);

    // asynchronous reset in the middle of a hold, key still held afterwards
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_both("pre_reset", 8'h03, 8'h03);
    rst_n = 1'b0;
    #1;
    expect_both("async_reset", 8'h00, 8'h00);
    model_reset();
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_both("held_thru_reset_e2", 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_both("held_thru_reset_e3", 8'h01, 8'h01);
    idle();
    idle();

    // overflow at all-9s
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
    expect_both("load_99", 8'h99, 8'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle();
    idle();
    expect_both("overflow_step", 8'h00, 8'h99);
    checkOutput("overflow_pulse_wrap", bus_wrap.overflow, 1'b1);
    checkOutput("overflow_pulse_sat", bus_sat.overflow, 1'b1);
    idle();
    checkOutput("overflow_drop_wrap", bus_wrap.overflow, 1'b0);
    checkOutput("overflow_drop_sat", bus_sat.overflow, 1'b0);

    // borrow and underflow
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    idle();
    expect_both("borrow", 8'h09, 8'h09);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("at_zero_before", bus_wrap.at_zero, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    idle();
    expect_both("underflow_step", 8'h99, 8'h00);
    checkOutput("underflow_pulse_wrap", bus_wrap.underflow, 1'b1);
    checkOutput("underflow_pulse_sat", bus_sat.underflow, 1'b1);
    checkOutput("at_zero_after_wrap", bus_wrap.at_zero, 1'b0);
    checkOutput("at_zero_after_sat", bus_sat.at_zero, 1'b1);
    idle();
    checkOutput("underflow_drop_wrap", bus_wrap.underflow, 1'b0);

    // rejected and accepted loads
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h3A);
    expect_both("load_bad", 8'h99, 8'h00);
    checkOutput("load_err_pulse_wrap", bus_wrap.load_err, 1'b1);
    checkOutput("load_err_pulse_sat", bus_sat.load_err, 1'b1);
    idle();
    checkOutput("load_err_drop", bus_wrap.load_err, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h42);
    expect_both("load_good", 8'h42, 8'h42);
    checkOutput("load_good_no_err", bus_wrap.load_err, 1'b0);

    // clear and load together with an up pulse
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
    expect_both("clear_beats_all", 8'h00, 8'h00);
    checkOutput("clear_no_overflow", bus_wrap.overflow, 1'b0);
    idle();
    expect_both("clear_pulse_dropped", 8'h00, 8'h00);

    // load together with a down pulse
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h27);
    expect_both("load_beats_down", 8'h27, 8'h27);
    idle();
    expect_both("load_pulse_dropped", 8'h27, 8'h27);

    // coincident up and down pulses, mid-range and at the top boundary
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    idle();
    expect_both("up_down_cancel", 8'h27, 8'h27);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    idle();
    expect_both("up_down_at_max", 8'h99, 8'h99);
    checkOutput("up_down_no_overflow", bus_wrap.overflow, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    $display("[TB] directed checks done, starting random phase");
    u_s = 1'b0;
    d_s = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(3) == 0) u_s = ~u_s;
      if ($urandom_range(3) == 0) d_s = ~d_s;
      c_r = ($urandom_range(49) == 0);
      l_r = ($urandom_range(19) == 0);
      if ($urandom_range(4) == 0) v_r = 8'($urandom);
      else v_r = int_to_bcd(int'($urandom_range(99)));
      applyStimulus(u_s, d_s, c_r, l_r, v_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Multi-digit decimal up/down counter that produces the packed BCD digits consumed by the seg7 decoders; one seg7 instance per digit, fed directly from `digits`.
- Takes raw level-sensitive key inputs, synchronises and edge-detects them, then counts one step per press.
- Supports synchronous clear and parallel load.
- Flags wrap/saturation events for the top-level game/score logic.

Parameters:
- NUM_DIGITS, 2, number of BCD digits (1..6); digit 0 is least significant.
- SATURATE, 0, 0 = wrap at max/zero; 1 = hold at all-9s / all-0s.

Ports:
- clk  in  1  system clock (50 MHz on board).
- reset  in  1  asynchronous, active-low reset; clears all state.
- up_key  in  1  raw up request, active-high level, asynchronous to clk.
- down_key  in  1  raw down request, active-high level, asynchronous to clk.
- clear  in  1  synchronous clear to zero, active-high.
- load  in  1  synchronous parallel load strobe, active-high.
- load_value  in  4*NUM_DIGITS  BCD value to load; digit i is bits [4i+3:4i].
- digits  out  4*NUM_DIGITS  current count, packed BCD, registered; same layout as load_value.
- overflow  out  1  one-cycle registered strobe: an increment was applied at all-9s.
- underflow  out  1  one-cycle registered strobe: a decrement was applied at all-0s.
- load_err  out  1  one-cycle registered strobe: a load was rejected because a digit was >9.
- at_zero  out  1  combinational; high when digits == 0.

Behaviour:
- Reset (reset = 0, async): digits = 0, overflow/underflow/load_err = 0, all synchroniser and edge flops = 0. Reset overrides everything mid-operation; no partial updates.
- Input path, per key:
  - 2-flop synchroniser, then a third flop for edge detection.
  - pulse = s2 & ~s3.
  - A key first sampled high at edge N updates `digits` at edge N+2, visible after N+2.
  - Holding a key gives exactly one step. Release then re-press gives another step.
  - A key held through reset release produces one step about 3 cycles after release.
- Priority per cycle: clear > load > count.
  - clear: digits <= 0. Strobes are 0 that cycle; any coincident pulse is discarded.
  - load: if every digit of load_value is <= 9, digits <= load_value and load_err <= 0. Otherwise digits are unchanged and load_err <= 1 for one cycle. Either way, a coincident pulse is discarded.
  - up pulse and down pulse in the same cycle: no change, no strobes.
- Increment (up pulse only):
  - Digit 0 +1; a digit at 9 becomes 0 and carries into the next digit (ripple).
  - At all-9s: SATURATE = 0 gives all-0s; SATURATE = 1 holds all-9s. overflow <= 1 in both cases.
- Decrement (down pulse only):
  - A digit at 0 becomes 9 and borrows from the next digit.
  - At all-0s: SATURATE = 0 gives all-9s; SATURATE = 1 holds all-0s. underflow <= 1 in both cases.
- overflow, underflow and load_err are 0 in every cycle without their event. They never assert together.
- digits never holds a value >9 in any digit under any stimulus.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_t (logic [3:0]).
  - constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0.
  - function is_valid_bcd(bcd_t).
- Sub-module bcd_digit (one per digit, generate loop):
  - inputs: clk, reset, inc, dec, set_en, set_val.
  - outputs: value, carry_out (value == 9 and inc), borrow_out (value == 0 and dec).
- Parent (bcd_counter) contains:
  - the synchronisers and edge detectors;
  - the priority logic;
  - the carry/borrow chain;
  - saturation gating and the strobe registers.
- Key synchroniser + edge detector is a small local sub-module, key_edge, instantiated twice.

Test Plan:
- Reset, then hold up_key for 20 cycles -> digits = 8'h01 exactly 3 edges after first sample. Release and press again -> 8'h02. Assert reset mid-hold -> digits = 0 immediately, asynchronously.
- Load 8'h99, then an up press (SATURATE = 0) -> digits = 8'h00, overflow high for exactly 1 cycle. Repeat with SATURATE = 1 -> digits stays 8'h99, overflow pulses.
- Load 8'h10, then a down press -> 8'h09 (borrow). Load 8'h00, then a down press (SATURATE = 0) -> 8'h99, underflow pulses, at_zero goes 1 -> 0.
- Load 8'h3A -> digits unchanged, load_err = 1 for one cycle. Load 8'h42 -> digits = 8'h42, load_err = 0.
- clear and load asserted in the same cycle as an up pulse -> digits = 0, no strobes. load with a down pulse -> load_value taken, no decrement. up and down pulses coincident -> no change.
- Random press/clear/load sequence over 2000 cycles checked against a reference integer model mod 100 -> no mismatch, no digit ever >9.
